// File: rtl/gray_counter_if.sv
// Control and count signals between a controller and the Gray counter.
// Clock and reset stay outside this bundle as plain ports.
interface gray_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             up;
    logic             load;
    logic             load_gray;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             wrap;

    modport master (
        output en, up, load, load_gray, din,
        input  bin, gray, wrap
    );

    modport slave (
        input  en, up, load, load_gray, din,
        output bin, gray, wrap
    );
endinterface

// File: rtl/gray_counter.sv
// Up/down counter that keeps binary and Gray-coded copies of its count,
// with parallel load in either format and a registered wrap-around pulse.
module gray_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    gray_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_load_gray;
    logic             w_wrap;

    always_comb begin
        w_next_bin  = bus.up ? (r_bin + ONE) : (r_bin - ONE);
        // Wrap is decided on the pre-count value: all-ones going up, zero going down.
        w_wrap      = bus.up ? (&r_bin) : ~(|r_bin);
        w_load_bin  = bus.load_gray ? gray2bin(bus.din) : bus.din;
        w_load_gray = bus.load_gray ? bus.din : bin2gray(bus.din);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= RESET_VAL;
            r_gray <= bin2gray(RESET_VAL);
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_bin  <= w_load_bin;
            r_gray <= w_load_gray;
            r_wrap <= 1'b0;
        end else if (bus.en) begin
            r_bin  <= w_next_bin;
            r_gray <= bin2gray(w_next_bin);
            r_wrap <= w_wrap;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign bus.bin  = r_bin;
    assign bus.gray = r_gray;
    assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter (WIDTH=4, RESET_VAL=0) with per-scenario tasks.
module tb_gray_counter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gray_counter_if #(.WIDTH(4)) bus ();

    gray_counter #(.WIDTH(4), .RESET_VAL(4'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; bus.en = 1'b1; bus.up = 1'b1; bus.load = 1'b0;
        bus.load_gray = 1'b0; bus.din = 4'b0110;
        @(posedge clk); #1;
        rst = 1'b0; bus.en = 1'b0;
        checks++;
        if (bus.bin !== 4'b0000) begin errors++; $display("FAIL reset_bin got %b want 0000", bus.bin); end
        checks++;
        if (bus.gray !== 4'b0000) begin errors++; $display("FAIL reset_gray got %b want 0000", bus.gray); end
        checks++;
        if (bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", bus.wrap); end
    endtask

    task automatic test_up_count();
        logic [3:0] exp_gray [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                      4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                      4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        logic [3:0] prev;
        logic [3:0] exp_bin;
        prev = bus.gray;
        bus.en = 1'b1; bus.up = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            exp_bin = 4'(i);
            checks++;
            if (bus.gray !== exp_gray[i]) begin errors++; $display("FAIL up_gray step %0d got %b want %b", i, bus.gray, exp_gray[i]); end
            checks++;
            if (bus.bin !== exp_bin) begin errors++; $display("FAIL up_bin step %0d got %b want %b", i, bus.bin, exp_bin); end
            checks++;
            if (bus.wrap !== (i == 16)) begin errors++; $display("FAIL up_wrap step %0d got %b want %b", i, bus.wrap, (i == 16)); end
            checks++;
            if ($countones(bus.gray ^ prev) != 1) begin errors++; $display("FAIL up_onebit step %0d got %b from %b", i, bus.gray, prev); end
            checks++;
            if (bus.gray !== (bus.bin ^ (bus.bin >> 1))) begin errors++; $display("FAIL up_invariant step %0d bin %b gray %b", i, bus.bin, bus.gray); end
            prev = bus.gray;
        end
        bus.en = 1'b0;
    endtask

    task automatic test_down_underflow();
        logic [3:0] exp_bin  [2] = '{4'b1111, 4'b1110};
        logic [3:0] exp_gray [2] = '{4'b1000, 4'b1001};
        logic       exp_wrap [2] = '{1'b1, 1'b0};
        bus.en = 1'b1; bus.up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.bin !== exp_bin[i]) begin errors++; $display("FAIL down_bin step %0d got %b want %b", i, bus.bin, exp_bin[i]); end
            checks++;
            if (bus.gray !== exp_gray[i]) begin errors++; $display("FAIL down_gray step %0d got %b want %b", i, bus.gray, exp_gray[i]); end
            checks++;
            if (bus.wrap !== exp_wrap[i]) begin errors++; $display("FAIL down_wrap step %0d got %b want %b", i, bus.wrap, exp_wrap[i]); end
            checks++;
            if (bus.gray !== (bus.bin ^ (bus.bin >> 1))) begin errors++; $display("FAIL down_invariant step %0d bin %b gray %b", i, bus.bin, bus.gray); end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_loads();
        // {load_gray, din, en, up} -> {bin, gray}; wrap is always 0 on a load
        logic       lg   [3] = '{1'b0, 1'b1, 1'b0};
        logic [3:0] din  [3] = '{4'b1010, 4'b1111, 4'b1111};
        logic       en   [3] = '{1'b0, 1'b0, 1'b1};
        logic [3:0] eb   [3] = '{4'b1010, 4'b1010, 4'b1111};
        logic [3:0] eg   [3] = '{4'b1111, 4'b1111, 4'b1000};
        for (int i = 0; i < 3; i++) begin
            bus.load = 1'b1; bus.load_gray = lg[i]; bus.din = din[i];
            bus.en = en[i]; bus.up = 1'b1;
            if (i == 2) begin
                // Park at 1111 first so a count that beat the load would wrap.
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            checks++;
            if (bus.bin !== eb[i]) begin errors++; $display("FAIL load_bin case %0d got %b want %b", i, bus.bin, eb[i]); end
            checks++;
            if (bus.gray !== eg[i]) begin errors++; $display("FAIL load_gray case %0d got %b want %b", i, bus.gray, eg[i]); end
            checks++;
            if (bus.wrap !== 1'b0) begin errors++; $display("FAIL load_wrap case %0d got %b want 0", i, bus.wrap); end
            checks++;
            if (bus.gray !== (bus.bin ^ (bus.bin >> 1))) begin errors++; $display("FAIL load_invariant case %0d bin %b gray %b", i, bus.bin, bus.gray); end
        end
        bus.load = 1'b0; bus.load_gray = 1'b0;
        // Now count from 1111 without the load: this edge must wrap.
        bus.en = 1'b1; bus.up = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b0;
        checks++;
        if (bus.bin !== 4'b0000 || bus.gray !== 4'b0000 || bus.wrap !== 1'b1) begin
            errors++; $display("FAIL post_load_wrap got bin %b gray %b wrap %b want 0000 0000 1", bus.bin, bus.gray, bus.wrap);
        end
    endtask

    task automatic test_back_to_back();
        logic       dir  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] eb   [7] = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd15, 4'd0, 4'd1};
        logic [3:0] eg   [7] = '{4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        logic       ew   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bus.en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.up = dir[i];
            @(posedge clk); #1;
            checks++;
            if (bus.bin !== eb[i] || bus.gray !== eg[i] || bus.wrap !== ew[i]) begin
                errors++;
                $display("FAIL dir_change step %0d got bin %b gray %b wrap %b want %b %b %b",
                         i, bus.bin, bus.gray, bus.wrap, eb[i], eg[i], ew[i]);
            end
            checks++;
            if (bus.gray !== (bus.bin ^ (bus.bin >> 1))) begin errors++; $display("FAIL dir_invariant step %0d bin %b gray %b", i, bus.bin, bus.gray); end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_hold();
        bus.load = 1'b1; bus.load_gray = 1'b0; bus.din = 4'b0110;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.en = 1'b0; bus.up = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.bin !== 4'b0110 || bus.gray !== 4'b0101 || bus.wrap !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d got bin %b gray %b wrap %b want 0110 0101 0", i, bus.bin, bus.gray, bus.wrap);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.en = 1'b1; bus.up = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; bus.load = 1'b1; bus.load_gray = 1'b0; bus.din = 4'b0101;
        @(posedge clk); #1;
        rst = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
        checks++;
        if (bus.bin !== 4'b0000 || bus.gray !== 4'b0000 || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got bin %b gray %b wrap %b want 0000 0000 0", bus.bin, bus.gray, bus.wrap);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0; bus.load_gray = 1'b0; bus.din = '0;
        @(posedge clk); #1;
        test_reset();
        test_up_count();
        test_down_underflow();
        test_loads();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
